// File: rtl/pipelined_parallel_adder_pkg.sv
// Shared mode encoding and default sizing for the pipelined add/subtract unit.
package pipelined_parallel_adder_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_STAGES = 4;

endpackage

// File: rtl/pipelined_parallel_adder_if.sv
// Operand/result streaming bundle; master is the operand source, slave is the adder.
interface pipelined_parallel_adder_if
  import pipelined_parallel_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/pipelined_parallel_adder_slice.sv
// Combinational CHUNK-bit ripple slice built from full_adder cells.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cmsb
);
  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co   = c[CHUNK];
  assign cmsb = c[CHUNK-1];
endmodule

// File: rtl/pipelined_parallel_adder.sv
// WIDTH-bit add/subtract with the carry chain cut into STAGES registered chunks.
// Whole pipe advances together when the output is empty or being accepted.
module pipelined_parallel_adder
  import pipelined_parallel_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input logic                       clk,
  input logic                       rst,
  pipelined_parallel_adder_if.slave bus
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  if (WIDTH % STAGES != 0) begin : g_param_check
    $error("WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
  end

  mode_e            mode;
  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign mode    = mode_e'(bus.sub);
  assign advance = ~bus.out_valid | bus.out_ready;

  always_comb begin
    b_eff   = bus.b;
    cin_eff = bus.cin;
    if (mode == MODE_SUB) begin
      b_eff   = ~bus.b;
      cin_eff = 1'b1;
    end
  end

  // Stage k owns chunk k; it carries the still-unadded upper operand bits
  // forward and accumulates the finished lower result bits behind it.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned SW = WIDTH - k * CHUNK;
    localparam int unsigned LO = (k + 1) * CHUNK;

    logic [SW-1:0]    src_a;
    logic [SW-1:0]    src_b;
    logic             src_c;
    logic             src_v;
    logic [CHUNK-1:0] cs;
    logic             co;
    logic             cm;
    logic [LO-1:0]    s_next;
    logic [LO-1:0]    s_q;
    logic             c_q;
    logic             v_q;

    if (k == 0) begin : g_head
      assign src_a  = bus.a;
      assign src_b  = b_eff;
      assign src_c  = cin_eff;
      assign src_v  = bus.in_valid;
      assign s_next = cs;
    end else begin : g_tail
      assign src_a  = g_stage[k-1].g_skew.a_q;
      assign src_b  = g_stage[k-1].g_skew.b_q;
      assign src_c  = g_stage[k-1].c_q;
      assign src_v  = g_stage[k-1].v_q;
      assign s_next = {cs, g_stage[k-1].s_q};
    end

    adder_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (src_a[CHUNK-1:0]),
      .b    (src_b[CHUNK-1:0]),
      .ci   (src_c),
      .s    (cs),
      .co   (co),
      .cmsb (cm)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= src_v;
        c_q <= co;
        s_q <= s_next;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [SW-CHUNK-1:0] a_q;
      logic [SW-CHUNK-1:0] b_q;
      logic                unused_cm;

      assign unused_cm = cm;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= src_a[SW-1:CHUNK];
          b_q <= src_b[SW-1:CHUNK];
        end
      end
    end else begin : g_last
      logic o_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          o_q <= 1'b0;
        end else if (advance) begin
          o_q <= cm ^ co;
        end
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = g_stage[STAGES-1].v_q;
  assign bus.sum       = g_stage[STAGES-1].s_q;
  assign bus.cout      = g_stage[STAGES-1].c_q;
  assign bus.ovf       = g_stage[STAGES-1].g_last.o_q;

endmodule

// File: tb/tb_pipelined_parallel_adder.sv
// Bench for pipelined_parallel_adder: STAGES=4 main instance plus STAGES=1 and STAGES=16 builds.
module tb_pipelined_parallel_adder;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_parallel_adder_if #(.WIDTH(W)) bus4  ();
  pipelined_parallel_adder_if #(.WIDTH(W)) bus1  ();
  pipelined_parallel_adder_if #(.WIDTH(W)) bus16 ();

  pipelined_parallel_adder #(.WIDTH(W), .STAGES(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
  pipelined_parallel_adder #(.WIDTH(W), .STAGES(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
  pipelined_parallel_adder #(.WIDTH(W), .STAGES(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  // Directed corner table: a, b, cin, sub -> sum, cout, ovf
  logic [W-1:0] c_a   [6] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h0005};
  logic [W-1:0] c_b   [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'hFFFF, 16'h0003};
  logic         c_cin [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic         c_sub [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [W-1:0] c_sum [6] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h0002};
  logic         c_co  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic         c_ov  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    int unsigned ua;
    int unsigned ub;
    int unsigned tot;
    int          sr;
    ua = a;
    ub = b;
    if (sub) begin
      tot    = ua - ub;
      e.cout = (ua >= ub);
      sr     = int'($signed(a)) - int'($signed(b));
    end else begin
      tot    = ua + ub + int'(cin);
      e.cout = tot[W];
      sr     = int'($signed(a)) + int'($signed(b)) + int'(cin);
    end
    e.sum = tot[W-1:0];
    e.ovf = (sr > 32767) || (sr < -32768);
    e.cyc = 0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({bus4.out_valid, bus4.cout, bus4.ovf, bus4.sum} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs4: got v=%b sum=%h cout=%b ovf=%b, expected all zero",
               bus4.out_valid, bus4.sum, bus4.cout, bus4.ovf);
    end
    n_checks++;
    if (bus1.out_valid !== 1'b0 || bus16.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid_builds: got v1=%b v16=%b, expected 0 0", bus1.out_valid, bus16.out_valid);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got in_ready=%b out_valid=%b, expected 1 0", bus4.in_ready, bus4.out_valid);
    end
  endtask

  task automatic test_corner();
    for (int i = 0; i < 6; i++) begin
      int lat;
      bit seen;
      bus4.a         = c_a[i];
      bus4.b         = c_b[i];
      bus4.cin       = c_cin[i];
      bus4.sub       = c_sub[i];
      bus4.in_valid  = 1'b1;
      bus4.out_ready = 1'b1;
      tick();
      bus4.in_valid = 1'b0;
      lat  = 1;
      seen = 1'b0;
      while (!seen && lat < 20) begin
        if (bus4.out_valid === 1'b1) seen = 1'b1;
        else begin
          tick();
          lat++;
        end
      end
      n_checks++;
      if (!seen || lat != 4) begin
        n_fail++;
        $display("FAIL corner_latency[%0d]: got %0d cycles (seen=%b), expected 4", i, lat, seen);
      end
      n_checks++;
      if ({bus4.sum, bus4.cout, bus4.ovf} !== {c_sum[i], c_co[i], c_ov[i]}) begin
        n_fail++;
        $display("FAIL corner_result[%0d]: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                 i, bus4.sum, bus4.cout, bus4.ovf, c_sum[i], c_co[i], c_ov[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    exp_t         q[$];
    exp_t         e;
    int           sent = 0;
    int           got  = 0;
    int           c    = 0;
    bit           have = 1'b0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    while (got < 8 && c < 60) begin
      bus4.out_ready = !(c >= 5 && c <= 7);
      #1;
      if (!bus4.out_ready) begin
        n_checks++;
        if (bus4.in_ready !== 1'b0 || bus4.out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_stall[%0d]: got in_ready=%b out_valid=%b, expected 0 1", c, bus4.in_ready, bus4.out_valid);
        end
      end
      if (bus4.out_valid === 1'b1) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_spurious[%0d]: got sum=%h with no op pending, expected no output", c, bus4.sum);
        end else begin
          e = q[0];
          if ({bus4.sum, bus4.cout, bus4.ovf} !== {e.sum, e.cout, e.ovf}) begin
            n_fail++;
            $display("FAIL b2b_result[%0d]: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                     got, bus4.sum, bus4.cout, bus4.ovf, e.sum, e.cout, e.ovf);
          end
          if (bus4.out_ready) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (!have && sent < 8) begin
        ra   = 16'($urandom);
        rb   = 16'($urandom);
        rc   = 1'($urandom);
        rs   = 1'($urandom);
        have = 1'b1;
      end
      bus4.in_valid = have;
      bus4.a        = ra;
      bus4.b        = rb;
      bus4.cin      = rc;
      bus4.sub      = rs;
      if (have && bus4.in_ready) begin
        q.push_back(model(ra, rb, rc, rs));
        sent++;
        have = 1'b0;
      end
      tick();
      c++;
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    n_checks++;
    if (got != 8 || q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results (%0d pending), expected 8 (0 pending)", got, q.size());
    end
  endtask

  task automatic test_bubbles();
    exp_t         q[$];
    exp_t         e;
    bit           pat [24];
    bit           exp_v;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    bus4.out_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      exp_v = (c >= 4) ? pat[c-4] : 1'b0;
      n_checks++;
      if (bus4.out_valid !== exp_v) begin
        n_fail++;
        $display("FAIL bubble_valid[%0d]: got out_valid=%b, expected %b", c, bus4.out_valid, exp_v);
      end
      if (bus4.out_valid === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if ({bus4.sum, bus4.cout, bus4.ovf} !== {e.sum, e.cout, e.ovf}) begin
          n_fail++;
          $display("FAIL bubble_result[%0d]: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                   c, bus4.sum, bus4.cout, bus4.ovf, e.sum, e.cout, e.ovf);
        end
      end
      pat[c] = (c < 12) && (c % 2 == 0);
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      bus4.in_valid = pat[c];
      bus4.a        = ra;
      bus4.b        = rb;
      bus4.cin      = rc;
      bus4.sub      = rs;
      if (pat[c] && bus4.in_ready) q.push_back(model(ra, rb, rc, rs));
      tick();
    end
    bus4.in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    int lat;
    bit seen;
    bus4.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus4.in_valid = 1'b1;
      bus4.a        = 16'($urandom);
      bus4.b        = 16'($urandom);
      bus4.cin      = 1'($urandom);
      bus4.sub      = 1'($urandom);
      tick();
    end
    bus4.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    n_checks++;
    if ({bus4.out_valid, bus4.cout, bus4.ovf, bus4.sum} !== '0 || bus4.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_outputs: got v=%b sum=%h cout=%b ovf=%b rdy=%b, expected v=0 sum=0000 cout=0 ovf=0 rdy=1",
               bus4.out_valid, bus4.sum, bus4.cout, bus4.ovf, bus4.in_ready);
    end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if (bus4.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_stale[%0d]: got out_valid=%b sum=%h, expected out_valid=0", c, bus4.out_valid, bus4.sum);
      end
    end
    bus4.a        = 16'h0003;
    bus4.b        = 16'h0004;
    bus4.cin      = 1'b0;
    bus4.sub      = 1'b0;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      if (bus4.out_valid === 1'b1) seen = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    n_checks++;
    if (!seen || lat != 4 || {bus4.sum, bus4.cout, bus4.ovf} !== {16'h0007, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_after: got sum=%h cout=%b ovf=%b lat=%0d seen=%b, expected sum=0007 cout=0 ovf=0 lat=4",
               bus4.sum, bus4.cout, bus4.ovf, lat, seen);
    end
    tick();
  endtask

  task automatic test_random_builds();
    exp_t         q1[$];
    exp_t         q16[$];
    exp_t         e;
    int           s1  = 0;
    int           s16 = 0;
    int           g1  = 0;
    int           g16 = 0;
    int           c   = 0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    bus1.out_ready  = 1'b1;
    bus16.out_ready = 1'b1;
    while ((g1 < 1000 || g16 < 1000) && c < 6000) begin
      if (bus1.out_valid === 1'b1) begin
        n_checks++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL s1_spurious: got sum=%h with no op pending, expected no output", bus1.sum);
        end else begin
          e = q1.pop_front();
          g1++;
          if ({bus1.sum, bus1.cout, bus1.ovf} !== {e.sum, e.cout, e.ovf} || cyc - e.cyc != 1) begin
            n_fail++;
            $display("FAIL s1_op[%0d]: got sum=%h cout=%b ovf=%b lat=%0d, expected sum=%h cout=%b ovf=%b lat=1",
                     g1, bus1.sum, bus1.cout, bus1.ovf, cyc - e.cyc, e.sum, e.cout, e.ovf);
          end
        end
      end
      if (bus16.out_valid === 1'b1) begin
        n_checks++;
        if (q16.size() == 0) begin
          n_fail++;
          $display("FAIL s16_spurious: got sum=%h with no op pending, expected no output", bus16.sum);
        end else begin
          e = q16.pop_front();
          g16++;
          if ({bus16.sum, bus16.cout, bus16.ovf} !== {e.sum, e.cout, e.ovf} || cyc - e.cyc != 16) begin
            n_fail++;
            $display("FAIL s16_op[%0d]: got sum=%h cout=%b ovf=%b lat=%0d, expected sum=%h cout=%b ovf=%b lat=16",
                     g16, bus16.sum, bus16.cout, bus16.ovf, cyc - e.cyc, e.sum, e.cout, e.ovf);
          end
        end
      end
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      bus1.in_valid = (s1 < 1000) && ($urandom_range(0, 3) != 0);
      bus1.a = ra; bus1.b = rb; bus1.cin = rc; bus1.sub = rs;
      if (bus1.in_valid && bus1.in_ready) begin
        e = model(ra, rb, rc, rs);
        e.cyc = cyc;
        q1.push_back(e);
        s1++;
      end
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      bus16.in_valid = (s16 < 1000) && ($urandom_range(0, 3) != 0);
      bus16.a = ra; bus16.b = rb; bus16.cin = rc; bus16.sub = rs;
      if (bus16.in_valid && bus16.in_ready) begin
        e = model(ra, rb, rc, rs);
        e.cyc = cyc;
        q16.push_back(e);
        s16++;
      end
      tick();
      c++;
    end
    bus1.in_valid  = 1'b0;
    bus16.in_valid = 1'b0;
    n_checks++;
    if (g1 != 1000 || g16 != 1000 || q1.size() != 0 || q16.size() != 0) begin
      n_fail++;
      $display("FAIL builds_count: got s1=%0d s16=%0d results, expected 1000 each", g1, g16);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test by 900us, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus4.in_valid  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.cin  = 1'b0; bus4.sub  = 1'b0; bus4.out_ready  = 1'b1;
    bus1.in_valid  = 1'b0; bus1.a  = '0; bus1.b  = '0; bus1.cin  = 1'b0; bus1.sub  = 1'b0; bus1.out_ready  = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0; bus16.out_ready = 1'b1;
    test_reset();
    test_corner();
    test_back_to_back();
    test_bubbles();
    test_reset_midstream();
    test_random_builds();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
